jtkiwi_linebuf: RTL and testbench
=================================

// Module: jtkiwi_linebuf
// PURPOSE
// Double-banked tile line buffer: the receiving end of the tile drawer's buf_addr/buf_we/buf_din port.
// While the drawer fills the write bank for the next line, the read bank is scanned out at pixel rate.
// Each pixel is erased as it is read. Banks swap at every line start.
// Sits between the tile drawer and the colour mixer/palette stage.
// PARAMETERS
// TRANSP  4'd0  pixel code treated as transparent (write suppressed when wr_din[3:0]==TRANSP)
// PORTS
// clk      in   1  system clock
// rst      in   1  reset: asynchronous, active-high
// pxl_cen  in   1  pixel clock enable; consecutive pulses are spaced >=2 clk apart
// hs       in   1  horizontal sync; the rising edge marks the line start
// lhbl     in   1  active-low horizontal blank (1 = active video)
// flip     in   1  screen flip: read address = hdump ^ 9'h1FF
// hdump    in   9  horizontal pixel counter; covers all 512 values every line
// wr_addr  in   9  drawer write address (x position)
// wr_we    in   1  drawer write strobe
// wr_din   in   9  {pal[4:0], pxl[3:0]}
// line     out  1  one-clk pulse on each bank swap; starts the drawer for the next line
// init     out  1  high while the power-up clear sweep runs
// pxl      out  9  pixel to the mixer; 0 = transparent/blank
// BEHAVIOUR
// Reset values: line=0, init=1, pxl=0, rd_bank=0, clr_cnt=0, hs_l=0, FSM=CLR.
// Storage: two 512x9 synchronous single-port RAMs, A and B. wr_bank = ~rd_bank.
// FSM CLR:
// - Each clk writes 0 to address clr_cnt in both A and B, then clr_cnt increments.
// - After address 511 is written, move to RUN and drop init on the next clk.
// - In CLR: wr_we is ignored, pxl=0, no line pulses. hs edges still update hs_l.
// FSM RUN:
// - Swap: hs_l <= hs each clk. When hs & ~hs_l: rd_bank toggles and line=1 for exactly 1 clk.
// - Drawer write: when wr_we and wr_din[3:0]!=TRANSP, the wr_bank RAM writes wr_din at wr_addr.
//   The write is 1 clk, with no backpressure. wr_addr wraps mod 512.
// - Read, cycle N (pxl_cen=1): rd_addr <= hdump ^ {9{flip}}; the read-bank RAM read is issued.
// - Cycle N+1:
//   - pxl <= lhbl_at_N ? ram_q : 9'd0 (lhbl sampled at cycle N).
//   - The read bank writes 0 at rd_addr (erase-after-read).
//   - pxl therefore appears 2 clk after the pxl_cen edge and holds until the next update.
// - Port conflict: drawer writes and erases always target different banks.
//   Each RAM therefore sees at most one access per clk.
// - Swap coinciding with a read or erase:
//   - Bank selection for a read/erase pair is latched at cycle N.
//   - A swap at N+1 does not redirect the erase.
//   - A drawer write in the swap cycle goes to the pre-swap wr_bank.
// - Erase happens regardless of lhbl, so a full hdump sweep leaves the read bank all-zero before its next swap.
// - Reset asserted mid-operation: state returns to CLR immediately (async).
//   RAM contents are undefined until the CLR sweep completes (512 clk after deassert).
// - Two hs rising edges with no pxl_cen in between simply toggle rd_bank twice; no error is flagged.
// TESTING
// 1. Reset release -> init=1 for 512 clk, then 0. Every address in A and B reads 0. pxl=0 throughout.
// 2. In RUN with rd_bank=0, write 9'h1A5 at wr_addr=10 (goes to B), then hs rise -> line pulse of 1 clk.
//    During the next line, pxl_cen with hdump=10 -> pxl=9'h1A5 2 clk later; B[10]=0 afterwards.
// 3. Write wr_din=9'h1E0 (pixel nibble 0) -> suppressed: the earlier value at that address is preserved and reads back unchanged.
// 4. flip=1, data 9'h077 at address 5 -> read at hdump=506 returns 9'h077.
//    Same line, hdump=5 returns the other content.
// 5. lhbl=0 during a read of nonzero data -> pxl=0, and the location is still erased.
// 6. wr_we in the same clk as the hs rising edge -> data lands in the pre-swap wr_bank.
//    It is visible immediately on the new read line; the new write bank is untouched.

Source files
------------

// File: rtl/jtkiwi_linebuf_if.sv
// jtkiwi_linebuf_if: drawer/scan-out/mixer signals of the tile line buffer
interface jtkiwi_linebuf_if;
  logic       pxl_cen, hs, lhbl, flip, wr_we, line, init;
  logic [8:0] hdump, wr_addr, wr_din, pxl;
  modport master(output pxl_cen, hs, lhbl, flip, hdump, wr_addr, wr_we, wr_din, input line, init, pxl);
  modport slave(input pxl_cen, hs, lhbl, flip, hdump, wr_addr, wr_we, wr_din, output line, init, pxl);
endinterface

// File: rtl/jtkiwi_linebuf.sv
// jtkiwi_linebuf: double-banked tile line buffer with erase-after-read scan-out
module jtkiwi_linebuf #(
  parameter logic [3:0] TRANSP = 4'd0
) (
  input logic clk,
  input logic rst,
  jtkiwi_linebuf_if.slave bus
);
  typedef enum logic {CLR, RUN} state_t;
  state_t state, state_d;
  logic [8:0] clr_cnt, rd_addr, raddr, q_a, q_b, addr_a, addr_b, din_a, din_b;
  logic       rd_bank, hs_l, rd_sel, lhbl_l, erase, run, drw, swap, er_a, er_b, we_a, we_b;
  logic [8:0] ram_a [512];
  logic [8:0] ram_b [512];
  assign bus.init = state == CLR;
  always_comb begin
    run     = state == RUN;
    state_d = (state == CLR && &clr_cnt) ? RUN : state;
    swap    = run && bus.hs && !hs_l;
    drw     = run && bus.wr_we && bus.wr_din[3:0] != TRANSP;
    raddr   = bus.hdump ^ {9{bus.flip}};
    // erase wins if a drawer write ever lands on the bank being erased
    er_a    = erase && !rd_sel;
    er_b    = erase && rd_sel;
    we_a    = !run || er_a || (drw && rd_bank);
    we_b    = !run || er_b || (drw && !rd_bank);
    addr_a  = !run ? clr_cnt : er_a ? rd_addr : (drw && rd_bank) ? bus.wr_addr : raddr;
    addr_b  = !run ? clr_cnt : er_b ? rd_addr : (drw && !rd_bank) ? bus.wr_addr : raddr;
    din_a   = (!run || er_a) ? 9'd0 : bus.wr_din;
    din_b   = (!run || er_b) ? 9'd0 : bus.wr_din;
  end
  always_ff @(posedge clk) begin
    if (we_a) ram_a[addr_a] <= din_a;
    q_a <= ram_a[addr_a];
  end
  always_ff @(posedge clk) begin
    if (we_b) ram_b[addr_b] <= din_b;
    q_b <= ram_b[addr_b];
  end
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      state   <= CLR;
      clr_cnt <= 9'd0;
      rd_bank <= 1'b0;
      hs_l    <= 1'b0;
      bus.line <= 1'b0;
      bus.pxl <= 9'd0;
      erase   <= 1'b0;
      rd_sel  <= 1'b0;
      lhbl_l  <= 1'b0;
      rd_addr <= 9'd0;
    end else begin
      state    <= state_d;
      hs_l     <= bus.hs;
      clr_cnt  <= run ? clr_cnt : clr_cnt + 9'd1;
      bus.line <= swap;
      rd_bank  <= rd_bank ^ swap;
      erase    <= run && bus.pxl_cen;
      if (run && bus.pxl_cen) begin
        rd_addr <= raddr;
        rd_sel  <= rd_bank;
        lhbl_l  <= bus.lhbl;
      end
      if (erase) bus.pxl <= lhbl_l ? (rd_sel ? q_b : q_a) : 9'd0;
    end
  end
endmodule

// File: tb/tb_jtkiwi_linebuf.sv
// tb_jtkiwi_linebuf: scoreboard bench for the double-banked line buffer
module tb_jtkiwi_linebuf;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  jtkiwi_linebuf_if bus();
  jtkiwi_linebuf dut(.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0;
  logic [8:0] exp_q[$];
  bit rb, cen_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor: a read issued at edge N shows on pxl right after edge N+1
  initial begin
    bit p;
    forever begin
      @(posedge clk);
      p = cen_d;
      cen_d = bus.pxl_cen && !bus.init;
      if (p) begin
        #1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pxl_unexpected: got %0h with no expected value queued", bus.pxl);
        end else check("pxl", bus.pxl, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [8:0] hd, input bit f, input bit l, input logic [8:0] e);
    @(negedge clk);
    bus.hdump = hd; bus.flip = f; bus.lhbl = l; bus.pxl_cen = 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.pxl_cen = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [8:0] d);
    @(negedge clk);
    bus.wr_we = 1; bus.wr_addr = a; bus.wr_din = d;
    @(negedge clk);
    bus.wr_we = 0;
  endtask

  task automatic swap(input bit w, input logic [8:0] a, input logic [8:0] d);
    @(negedge clk);
    bus.hs = 1;
    if (w) begin bus.wr_we = 1; bus.wr_addr = a; bus.wr_din = d; end
    @(posedge clk); #1;
    check("line_pulse", bus.line, 1);
    rb = !rb;
    @(negedge clk);
    bus.hs = 0; bus.wr_we = 0;
    @(posedge clk); #1;
    check("line_width", bus.line, 0);
  endtask

  initial begin
    int n;
    bit pxl_ok;
    bus.pxl_cen = 0; bus.hs = 0; bus.lhbl = 1; bus.flip = 0;
    bus.hdump = 0; bus.wr_addr = 0; bus.wr_we = 0; bus.wr_din = 0;
    rb = 0;
    repeat (2) @(negedge clk);
    check("rst_init", bus.init, 1);
    check("rst_pxl", bus.pxl, 0);
    check("rst_line", bus.line, 0);
    rst = 0;
    n = 0; pxl_ok = 1;
    do begin
      @(posedge clk); #1;
      n++;
      if (bus.pxl !== 9'd0 || bus.line !== 1'b0) pxl_ok = 0;
    end while (bus.init && n < 600);
    check("init_len", n, 512);
    check("clr_quiet", pxl_ok, 1);
    for (int i = 0; i < 512; i++) rd(9'(i), 0, 1, 9'd0);
    swap(0, 0, 0);
    for (int i = 0; i < 512; i++) rd(9'(i), 0, 1, 9'd0);
    swap(0, 0, 0);
    // basic write to B, swap, read then erased
    wr(10, 9'h1A5);
    swap(0, 0, 0);
    rd(10, 0, 1, 9'h1A5);
    rd(10, 0, 1, 9'h000);
    // transparent pixel suppressed
    wr(20, 9'h0C3);
    wr(20, 9'h1E0);
    swap(0, 0, 0);
    rd(20, 0, 1, 9'h0C3);
    // flip
    wr(5, 9'h077);
    wr(506, 9'h111);
    swap(0, 0, 0);
    rd(506, 1, 1, 9'h077);
    rd(5, 1, 1, 9'h111);
    rd(506, 1, 1, 9'h000);
    // blanking masks output but still erases
    wr(7, 9'h1F3);
    swap(0, 0, 0);
    rd(7, 0, 0, 9'h000);
    rd(7, 0, 1, 9'h000);
    // write coinciding with swap lands in pre-swap write bank
    swap(1, 30, 9'h0AB);
    rd(30, 0, 1, 9'h0AB);
    swap(0, 0, 0);
    rd(30, 0, 1, 9'h000);
    // asynchronous reset mid-operation
    wr(40, 9'h155);
    @(negedge clk);
    rst = 1;
    #1;
    check("midrst_init", bus.init, 1);
    check("midrst_pxl", bus.pxl, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
